ahb_slave_mem: RTL

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ahb_slave_mem
//
// AHB-Lite slave backed by an internal byte-lane-writable memory. Valid
// transfers get a configurable number of wait states (separately for reads
// and writes). Oversized, misaligned or out-of-range transfers get the
// two-cycle ERROR response. Reads return the full aligned bus word.
//
// Parameters
//   DATA_WIDTH  bus width in bits (32 or 64)
//   MEM_BYTES   memory size in bytes (power of two, >= DATA_WIDTH/8)
//   READ_WAIT   wait states per read  (0..15)
//   WRITE_WAIT  wait states per write (0..15)
//
// Ports
//   HCLK       in   clock, rising edge
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select
//   HADDR      in   byte address [31:0]
//   HTRANS     in   IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size, 2^HSIZE bytes
//   HWDATA     in   write data (data phase)
//   HREADYIN   in   bus ready
//   HRDATA     out  read data, zero outside a completing read
//   HREADYOUT  out  slave ready
//   HRESP      out  00 = OKAY, 01 = ERROR
// ---------------------------------------------------------------------------
module ahb_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADYIN,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int WORDS  = MEM_BYTES / BYTES;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW     = LANE_W + IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]    r_state, w_state_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic          r_dp_valid, w_dp_valid_next;
  logic          r_dp_write;
  logic [2:0]    r_dp_size;
  logic [AW-1:0] r_dp_addr;

  logic          w_accept, w_size_ok, w_aligned, w_in_range, w_valid;
  logic [31:0]   w_align_mask;
  logic [3:0]    w_waits;
  logic          w_complete, w_commit;
  logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic [BYTES-1:0] w_be;
  logic          w_unused_htrans;

  // Only the sequential-vs-nonsequential distinction is irrelevant here.
  assign w_unused_htrans = HTRANS[0];

  // A new address phase can only be taken in a cycle where this slave is
  // driving HREADYOUT high: idle/completing cycles and the second error cycle.
  assign w_accept = HSEL & HREADYIN & HTRANS[1] &
                    ((r_state == ST_IDLE) | (r_state == ST_ERR2));

  assign w_size_ok    = (HSIZE <= 3'(LANE_W));
  assign w_align_mask = (32'd1 << HSIZE) - 32'd1;
  assign w_aligned    = ((HADDR & w_align_mask) == 32'd0);
  assign w_in_range   = (HADDR < 32'(MEM_BYTES));
  assign w_valid      = w_size_ok & w_aligned & w_in_range;
  assign w_waits      = HWRITE ? 4'(WRITE_WAIT) : 4'(READ_WAIT);

  // The completing data-phase cycle of a valid transfer is ST_IDLE with a
  // pending data phase.
  assign w_complete = (r_state == ST_IDLE) & r_dp_valid;
  assign w_commit   = w_complete & r_dp_write;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_dp_valid_next = r_dp_valid;
    case (r_state)
      ST_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR1: begin
        w_state_next = ST_ERR2;
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_dp_valid_next = 1'b0;
        if (w_accept) begin
          if (!w_valid) begin
            w_state_next = ST_ERR1;
          end else begin
            w_dp_valid_next = 1'b1;
            if (w_waits != 4'd0) begin
              w_state_next = ST_WAIT;
              w_cnt_next   = w_waits;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_size  <= 3'd0;
      r_dp_addr  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_dp_valid <= w_dp_valid_next;
      if (w_accept) begin
        r_dp_write <= HWRITE;
        r_dp_size  <= HSIZE;
        r_dp_addr  <= HADDR[AW-1:0];
      end
    end
  end

  // Byte lanes covered by the data-phase transfer.
  always_comb begin
    w_be = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_be[b] = (b >= int'(r_dp_addr[LANE_W-1:0])) &&
                (b <  int'(r_dp_addr[LANE_W-1:0]) + (1 << r_dp_size));
    end
  end

  assign w_wr_idx = r_dp_addr[AW-1:LANE_W];
  // Look up the word of a newly accepted address; otherwise keep tracking
  // the pending data phase so the word is fresh after the last wait cycle.
  assign w_rd_idx = w_accept ? HADDR[AW-1:LANE_W] : r_dp_addr[AW-1:LANE_W];

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_mem_q;

  // Memory has no reset: contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_be[b]) begin
          r_mem[w_wr_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
        end
      end
    end
    r_mem_q <= r_mem[w_rd_idx];
  end

  // A read looked up on the same edge that commits a write to that word sees
  // the old contents; remember the written lanes and patch them on output.
  logic [BYTES-1:0]      r_byp_be;
  logic [DATA_WIDTH-1:0] r_byp_data;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_byp_be   <= '0;
      r_byp_data <= '0;
    end else begin
      r_byp_be   <= (w_commit && (w_wr_idx == w_rd_idx)) ? w_be : '0;
      r_byp_data <= HWDATA;
    end
  end

  logic [DATA_WIDTH-1:0] w_rd_merged;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign w_rd_merged[gi*8 +: 8] = r_byp_be[gi] ? r_byp_data[gi*8 +: 8]
                                                 : r_mem_q[gi*8 +: 8];
  end

  assign HRDATA    = (w_complete && !r_dp_write) ? w_rd_merged : '0;
  assign HREADYOUT = ~((r_state == ST_WAIT) | (r_state == ST_ERR1));
  assign HRESP     = ((r_state == ST_ERR1) | (r_state == ST_ERR2)) ? 2'b01 : 2'b00;

endmodule
